cache_arbiter: RTL and testbench

CACHE_ARBITER -- requirements
Module: cache_arbiter

---
 rtl/cache_arbiter.sv | 74 +++++++
 tb/tb_cache_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one L2 port between the I-cache and D-cache miss paths, preferring D
// but granting a waiting I after STARVE_LIMIT consecutive D grants.
module cache_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_pmem_read,
  input  logic [15:0]  i_pmem_address,
  output logic [127:0] i_pmem_rdata,
  output logic         i_pmem_resp,
  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [15:0]  d_pmem_address,
  input  logic [127:0] d_pmem_wdata,
  output logic [127:0] d_pmem_rdata,
  output logic         d_pmem_resp,
  output logic         l2_read,
  output logic         l2_write,
  output logic [15:0]  l2_address,
  output logic [127:0] l2_wdata,
  input  logic [127:0] l2_rdata,
  input  logic         l2_resp,
  output logic         grant_i,
  output logic         grant_d
);
  localparam int CW = STARVE_LIMIT > 0 ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;
  state_t state, state_n;
  logic [CW-1:0] starve_cnt;
  logic [15:0] addr_q;
  logic [127:0] wdata_q;
  logic write_q;
  logic d_win, i_win;
  always_comb begin
    d_win = state == IDLE && (d_pmem_read || d_pmem_write) && (!i_pmem_read || starve_cnt < LIMIT);
    i_win = state == IDLE && i_pmem_read && !d_win;
    state_n = d_win ? D_BUSY : i_win ? I_BUSY : (state != IDLE && l2_resp) ? IDLE : state;
  end
  // the L2 request is launched only from the registers captured at grant time
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      starve_cnt <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
    end else begin
      state <= state_n;
      if (d_win) begin
        addr_q <= d_pmem_address;
        wdata_q <= d_pmem_wdata;
        write_q <= d_pmem_write;
        if (i_pmem_read && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 1'b1;
      end else if (i_win) begin
        addr_q <= i_pmem_address;
        wdata_q <= '0;
        write_q <= 1'b0;
        starve_cnt <= '0;
      end
    end
  end
  assign grant_i = state == I_BUSY;
  assign grant_d = state == D_BUSY;
  assign l2_read = (grant_i || grant_d) && !write_q;
  assign l2_write = (grant_i || grant_d) && write_q;
  assign l2_address = addr_q;
  assign l2_wdata = wdata_q;
  assign i_pmem_resp = l2_resp && grant_i;
  assign d_pmem_resp = l2_resp && grant_d;
  assign i_pmem_rdata = l2_rdata;
  assign d_pmem_rdata = l2_rdata;
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: directed scenarios plus random traffic checked against a transaction-level owner model.
module tb_cache_arbiter;
  localparam int LIM = 4;
  logic clk = 1'b0;
  logic reset;
  logic i_pmem_read, d_pmem_read, d_pmem_write, l2_resp;
  logic [15:0] i_pmem_address, d_pmem_address;
  logic [127:0] d_pmem_wdata, l2_rdata;
  logic [127:0] i_pmem_rdata, d_pmem_rdata, l2_wdata;
  logic i_pmem_resp, d_pmem_resp, l2_read, l2_write, grant_i, grant_d;
  logic [15:0] l2_address;
  int n_vec = 0;
  int n_err = 0;
  int m_own = 0;
  int m_cnt = 0;
  logic [15:0] m_addr = '0;
  logic [127:0] m_wdata = '0;
  logic m_wr = 1'b0;
  string dut_log = "";
  logic pg_i = 1'b0;
  logic pg_d = 1'b0;

  always #5 clk = ~clk;

  cache_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .grant_i(grant_i), .grant_d(grant_d)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] want);
    n_vec++;
    assert (obs === want) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  // owner 0 = nobody, 1 = I, 2 = D; updated once per clock from the arbitration rules
  task automatic cyc();
    @(negedge clk);
    chk("grant_i", 128'(grant_i), 128'(m_own == 1));
    chk("grant_d", 128'(grant_d), 128'(m_own == 2));
    chk("l2_read", 128'(l2_read), 128'(m_own != 0 && !m_wr));
    chk("l2_write", 128'(l2_write), 128'(m_own != 0 && m_wr));
    chk("l2_address", 128'(l2_address), 128'(m_addr));
    chk("l2_wdata", l2_wdata, m_wdata);
    chk("i_resp", 128'(i_pmem_resp), 128'(l2_resp && m_own == 1));
    chk("d_resp", 128'(d_pmem_resp), 128'(l2_resp && m_own == 2));
    chk("i_rdata", i_pmem_rdata, l2_rdata);
    chk("d_rdata", d_pmem_rdata, l2_rdata);
    if (grant_i && !pg_i) dut_log = {dut_log, "I"};
    if (grant_d && !pg_d) dut_log = {dut_log, "D"};
    pg_i = grant_i;
    pg_d = grant_d;
    @(posedge clk);
    if (reset) begin
      m_own = 0; m_cnt = 0; m_addr = '0; m_wdata = '0; m_wr = 1'b0;
    end else if (m_own == 0) begin
      if ((d_pmem_read || d_pmem_write) && (!i_pmem_read || m_cnt < LIM)) begin
        m_own = 2; m_addr = d_pmem_address; m_wdata = d_pmem_wdata; m_wr = d_pmem_write;
        if (i_pmem_read && m_cnt < LIM) m_cnt++;
      end else if (i_pmem_read) begin
        m_own = 1; m_addr = i_pmem_address; m_wdata = '0; m_wr = 1'b0; m_cnt = 0;
      end
    end else if (l2_resp) m_own = 0;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0; l2_resp = 0;
    i_pmem_address = '0; d_pmem_address = '0; d_pmem_wdata = '0; l2_rdata = '0;
    repeat (2) cyc();
    reset = 1'b0;
    cyc();
    // lone I read, response after three wait cycles
    i_pmem_read = 1; i_pmem_address = 16'h1230;
    cyc();
    i_pmem_read = 0;
    chk("r30_read", 128'(l2_read), 128'(1));
    chk("r30_addr", 128'(l2_address), 128'(16'h1230));
    repeat (3) cyc();
    l2_resp = 1; l2_rdata = {$urandom, $urandom, $urandom, $urandom};
    cyc();
    chk("r30_read_off", 128'(l2_read), 128'(0));
    chk("r30_resp_off", 128'(i_pmem_resp), 128'(0));
    l2_resp = 0;
    // simultaneous I and D: D first, then I
    i_pmem_read = 1; d_pmem_read = 1; d_pmem_address = 16'h4444;
    cyc();
    chk("r31_d_first", 128'(grant_d), 128'(1));
    d_pmem_read = 0; l2_resp = 1;
    cyc();
    l2_resp = 0;
    chk("r31_idle", 128'({grant_i, grant_d}), 128'(0));
    cyc();
    chk("r31_i_next", 128'(grant_i), 128'(1));
    i_pmem_read = 0; l2_resp = 1;
    cyc();
    l2_resp = 0;
    // starvation bound with I held high
    reset = 1;
    cyc();
    reset = 0; dut_log = "";
    i_pmem_read = 1; d_pmem_read = 1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      l2_resp = 1;
      cyc();
      l2_resp = 0;
    end
    i_pmem_read = 0; d_pmem_read = 0;
    cyc();
    n_vec++;
    assert (dut_log == "DDDDID") else begin
      n_err++;
      $error("FAIL r32_order observed=%s expected=DDDDID", dut_log);
    end
    // D write whose request drops after one cycle
    d_pmem_write = 1; d_pmem_address = 16'h8000; d_pmem_wdata = {16{8'hA5}};
    cyc();
    d_pmem_write = 0; d_pmem_wdata = '0; d_pmem_address = '0;
    chk("r33_write", 128'(l2_write), 128'(1));
    repeat (2) cyc();
    chk("r33_addr", 128'(l2_address), 128'(16'h8000));
    chk("r33_wdata", l2_wdata, {16{8'hA5}});
    chk("r33_read", 128'(l2_read), 128'(0));
    l2_resp = 1;
    cyc();
    l2_resp = 0;
    chk("r33_done", 128'(grant_d), 128'(0));
    // reset aborts an I transaction
    i_pmem_read = 1; i_pmem_address = 16'h0BEE;
    cyc();
    i_pmem_read = 0;
    chk("r34_busy", 128'(grant_i), 128'(1));
    reset = 1;
    cyc();
    reset = 0; l2_resp = 1;
    cyc();
    chk("r34_grant", 128'(grant_i), 128'(0));
    chk("r34_read", 128'(l2_read), 128'(0));
    chk("r34_resp", 128'(i_pmem_resp), 128'(0));
    // stray response while idle
    repeat (2) cyc();
    chk("r35_resp", 128'({i_pmem_resp, d_pmem_resp}), 128'(0));
    chk("r35_state", 128'({grant_i, grant_d}), 128'(0));
    l2_resp = 0;
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      reset = $urandom_range(99) == 0;
      i_pmem_read = $urandom_range(2) == 0;
      d_pmem_read = $urandom_range(2) == 0;
      d_pmem_write = $urandom_range(3) == 0;
      i_pmem_address = 16'($urandom);
      d_pmem_address = 16'($urandom);
      d_pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
      l2_rdata = {$urandom, $urandom, $urandom, $urandom};
      l2_resp = $urandom_range(3) == 0;
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
